// File: rtl/dbi_link_arbiter.sv
// dbi_link_arbiter
//   Shares one BW-bit DBI-encoded output link among NREQ requesters.
//   Requesters are granted whole bursts in round-robin order. Each accepted
//   beat is DC-balanced against the last word actually transferred on the
//   link: it is sent inverted (link_dbi=1) when more than BW/2 lines would
//   toggle.
//
//   Optional feature macro: DBI_STATS_EN (adds stats_beats / stats_inv).
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   req_valid/ready   per-requester beat handshake (at most one ready high)
//   req_data          requester i occupies bits [i*BW +: BW]
//   req_last          final beat of a requester's burst
//   dbi_en            inversion enable, sampled per accepted beat
//   link_valid/ready  output link handshake
//   link_data         encoded link word
//   link_dbi          1 = link_data is the inverted payload
//   grant_id          current or most recent grantee
//   stats_beats       (DBI_STATS_EN) saturating count of link handshakes
//   stats_inv         (DBI_STATS_EN) saturating count of inverted handshakes
module dbi_link_arbiter #(
  parameter int NREQ      = 4,
  parameter int BW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*BW-1:0]      req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    dbi_en,
  output logic                    link_valid,
  input  logic                    link_ready,
  output logic [BW-1:0]           link_data,
  output logic                    link_dbi,
  output logic [$clog2(NREQ)-1:0] grant_id
`ifdef DBI_STATS_EN
  ,
  output logic [31:0]             stats_beats,
  output logic [31:0]             stats_inv
`endif
);

  localparam int GW = $clog2(NREQ);
  localparam int OW = $clog2(BW) + 1;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr_ptr;
  logic [CW-1:0]   beat_cnt;
  logic [BW-1:0]   prev_link;

  logic [BW-1:0]   req_word [NREQ];
  logic [GW-1:0]   pick;
  logic            any_valid;
  logic            in_burst, load_ok, accept, handshake;
  logic            last_beat, burst_end, invert;
  logic [BW-1:0]   gword, ref_word, toggles;
  logic [OW-1:0]   ones;
  logic [GW-1:0]   next_rr;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign req_word[i]  = req_data[i*BW +: BW];
    assign req_ready[i] = in_burst && load_ok && (grant_id == GW'(i));
  end

  // Round-robin search: first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    int idx;
    idx       = 0;
    pick      = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        pick      = GW'(idx);
      end
    end
  end

  assign in_burst  = (state == BURST);
  assign load_ok   = !link_valid || link_ready;
  assign gword     = req_word[grant_id];
  assign accept    = in_burst && req_valid[grant_id] && load_ok;
  assign handshake = link_valid && link_ready;

  // When the pending word completes this cycle it becomes the reference,
  // so bypass it ahead of prev_link.
  assign ref_word = handshake ? link_data : prev_link;
  assign toggles  = gword ^ ref_word;

  always_comb begin
    ones = '0;
    for (int b = 0; b < BW; b++) ones = ones + OW'(toggles[b]);
  end

  // Tie (exactly BW/2 toggles) is sent uninverted.
  assign invert = dbi_en && (ones > OW'(BW/2));

  // A burst ends on its last beat, on the MAX_BURST-th beat, or when the
  // grantee goes idle while the link could take a beat. Backpressure alone
  // never ends a burst.
  assign last_beat = req_last[grant_id] || (beat_cnt == CW'(MAX_BURST-1));
  assign burst_end = in_burst && load_ok && (!req_valid[grant_id] || last_beat);
  assign next_rr   = (grant_id == GW'(NREQ-1)) ? '0 : grant_id + GW'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = BURST;
      BURST:   if (burst_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      grant_id   <= '0;
      beat_cnt   <= '0;
      prev_link  <= '0;
      link_valid <= 1'b0;
      link_data  <= '0;
      link_dbi   <= 1'b0;
    end else begin
      if (state == IDLE && any_valid) begin
        grant_id <= pick;
        beat_cnt <= '0;
      end
      if (accept)    beat_cnt  <= beat_cnt + CW'(1);
      if (burst_end) rr_ptr    <= next_rr;
      if (handshake) prev_link <= link_data;
      if (accept) begin
        link_valid <= 1'b1;
        link_data  <= invert ? ~gword : gword;
        link_dbi   <= invert;
      end else if (link_ready) begin
        // Drop valid but hold data/dbi so the bus lines stay quiet.
        link_valid <= 1'b0;
      end
    end
  end

`ifdef DBI_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stats_beats <= '0;
      stats_inv   <= '0;
    end else if (handshake) begin
      if (stats_beats != '1)           stats_beats <= stats_beats + 32'd1;
      if (link_dbi && stats_inv != '1) stats_inv   <= stats_inv + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dbi_link_arbiter.md
Name: dbi_link_arbiter

Overview:
- Shares one BW-bit DBI-encoded output link among NREQ requesters.
- Round-robin burst arbitration with valid/ready handshakes on both sides.
- Each beat is DC-balanced against the last word actually driven on the link: the word is inverted when more than BW/2 lines would toggle.
- Sits between the systolic-array output collectors and the shared inter-tile bus; owns the per-link DBI state.

Parameters:
- NREQ, 4, number of requesters (≥2).
- BW, 32, data width per beat.
- MAX_BURST, 8, maximum beats per grant before forced rotation (≥1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_data  input  NREQ*BW  requester i occupies bits [i*BW +: BW].
- req_last  input  NREQ  marks the final beat of a requester's burst.
- req_ready  output  NREQ  per-requester beat accept; at most one bit high.
- dbi_en  input  1  enables inversion; sampled per accepted beat.
- link_valid  output  1  link beat valid.
- link_ready  input  1  link sink accept.
- link_data  output  BW  encoded link word.
- link_dbi  output  1  1 = link_data is the inverted payload.
- grant_id  output  $clog2(NREQ)  index of the current or most recent grantee.

Behaviour:
- Reset values: link_valid=0, link_data=0, link_dbi=0, req_ready=0, grant_id=0. Internal: prev_link=0, rr_ptr=0, beat_cnt=0, FSM=IDLE. Reset wins over all other events, including mid-burst; a beat in flight is discarded.
- FSM IDLE:
  - If any req_valid is set, grant the first requester with valid set, searching from rr_ptr upward with wrap.
  - Latch grant_id, clear beat_cnt, go to BURST. Arbitration costs one cycle; req_ready stays low in IDLE.
  - If no req_valid is set, stay in IDLE.
- FSM BURST:
  - load_ok = !link_valid || link_ready.
  - req_ready[grant_id] = load_ok (combinational). All other req_ready bits are 0.
  - Accept = req_valid[g] && req_ready[g].
- Encode on accept:
  - x = req_data[g] ^ prev_link; ones = popcount(x), width $clog2(BW)+1.
  - If dbi_en && ones > BW/2: link_data <= ~req_data[g], link_dbi <= 1.
  - Otherwise: link_data <= req_data[g], link_dbi <= 0.
  - A tie (ones == BW/2) is not inverted.
  - Set link_valid <= 1. Latency is one cycle from accept to link_valid.
- prev_link updates only on a link handshake (link_valid && link_ready), taking the link_data value being transferred. Encoding always compares against the last word transferred on the link, not against the pending output register.
- Simultaneous handshake and accept in the same cycle: compare against the word completing that cycle, i.e. bypass the old link_data into the XOR.
- No accept && link_ready: link_valid <= 0. link_data and link_dbi hold their values, so the bus does not toggle.
- Burst termination on accept: beat_cnt increments. The burst ends on req_last[g], or when beat_cnt reaches MAX_BURST-1 on this beat.
- Burst termination without accept: if req_valid[g]=0 while load_ok=1, the burst ends (requester idle). Backpressure (load_ok=0) never ends a burst.
- On any burst end: rr_ptr <= (g+1) mod NREQ, FSM goes to IDLE. grant_id holds.

Optional Feature:
- Macro: DBI_STATS_EN.
- When defined, adds two outputs:
  - stats_beats: 32-bit count of link handshakes.
  - stats_inv: 32-bit count of link handshakes with link_dbi=1.
  - Both saturate at all ones and reset to 0.
- When undefined, neither port nor its counters exist, and behaviour is otherwise identical.

Test Plan:
- Reset then single beat: req0 sends 0x0000_00FF with last=1, dbi_en=1, link_ready=1 → link_data=0x0000_00FF, link_dbi=0, link_valid high for exactly one cycle, grant_id=0.
- Inversion: prev_link=0; send 0xFFFF_FFF0 (28 toggles) → link_data=0x0000_000F, link_dbi=1. Next beat 0x0000_0000 → XOR with 0x0000_000F gives 4 toggles → sent as-is, link_dbi=0.
- Tie and disable: prev_link=0; send 0x0000_FFFF (16 toggles) → no inversion. Send 0xFFFF_FFFF with dbi_en=0 → link_dbi=0, data unchanged.
- Round-robin and MAX_BURST: all four requesters continuously valid, no req_last → grants rotate 0,1,2,3,0 with exactly 8 beats each; no requester is starved.
- Backpressure: hold link_ready=0 for 5 cycles mid-burst → req_ready low, link_data/link_dbi stable, burst not ended. Release → beats resume with no loss or duplication, and encoding is based on the last transferred word.
- Reset mid-burst: assert reset during a req2 burst with link_valid=1 → next cycle all outputs at reset values, rr_ptr=0, and a subsequent encode compares against 0.
